// File: rtl/rv_pc_pkg.sv
// rv_pc_pkg: shared types and helpers for the program-counter unit.
//   pc_op_e    : next-PC control operation from decode.
//   pc_state_e : run/halt/fault FSM states of rv_pc_unit.
//   imm_i/j/b  : RV32 immediate extraction, sign-extended to 32 bits.
package rv_pc_pkg;

   typedef enum logic [1:0] {
      OP_SEQ    = 2'd0,
      OP_JAL    = 2'd1,
      OP_JALR   = 2'd2,
      OP_BRANCH = 2'd3
   } pc_op_e;

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      HALTED,
      FAULT
   } pc_state_e;

   function automatic logic [31:0] imm_i(input logic [31:0] instr);
      return {{20{instr[31]}}, instr[31:20]};
   endfunction

   function automatic logic [31:0] imm_j(input logic [31:0] instr);
      return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
   endfunction

   function automatic logic [31:0] imm_b(input logic [31:0] instr);
      return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   endfunction

endpackage

// File: rtl/rv_pc_target.sv
// rv_pc_target: combinational next-PC target, redirect and misalignment logic.
// Config macro: PC_MISALIGN_CHK_EN (flag misaligned redirect targets;
// when undefined, target bit1 is forced low and misalign_o is 0).
// Ports:
//   pc_i          current PC
//   op_i          pc_op_e control
//   br_taken_i    branch condition (OP_BRANCH only)
//   instr_i       instruction supplying the immediate
//   rs1_i         JALR base
//   trap_vector_i trap target (low two bits are dropped)
//   target_o      next PC for the non-trap path (pc+4 when no redirect)
//   trap_target_o aligned trap target
//   redirect_o    JAL, JALR or taken branch
//   misalign_o    redirect target not 4-byte aligned
module rv_pc_target
   import rv_pc_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] pc_i,
   input  logic [1:0]      op_i,
   input  logic            br_taken_i,
   input  logic [31:0]     instr_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] trap_vector_i,
   output logic [XLEN-1:0] target_o,
   output logic [XLEN-1:0] trap_target_o,
   output logic            redirect_o,
   output logic            misalign_o
);

   logic [XLEN-1:0] seq_tgt;
   logic [XLEN-1:0] jalr_sum;
   logic [XLEN-1:0] raw_tgt;

   assign seq_tgt  = pc_i + XLEN'(4);
   assign jalr_sum = rs1_i + XLEN'($signed(imm_i(instr_i)));

   always_comb begin
      raw_tgt    = seq_tgt;
      redirect_o = 1'b0;
      unique case (pc_op_e'(op_i))
         OP_JAL: begin
            raw_tgt    = pc_i + XLEN'($signed(imm_j(instr_i)));
            redirect_o = 1'b1;
         end
         OP_JALR: begin
            raw_tgt    = {jalr_sum[XLEN-1:1], 1'b0};
            redirect_o = 1'b1;
         end
         OP_BRANCH: begin
            if (br_taken_i) begin
               raw_tgt    = pc_i + XLEN'($signed(imm_b(instr_i)));
               redirect_o = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign trap_target_o = {trap_vector_i[XLEN-1:2], 2'b00};

   // Opcode bits never feed an immediate.
   logic unused_bits;

`ifdef PC_MISALIGN_CHK_EN
   assign target_o    = raw_tgt;
   assign misalign_o  = redirect_o && (raw_tgt[1:0] != 2'b00);
   assign unused_bits = ^instr_i[6:0];
`else
   // bit0 is already clear on every path, so only bit1 needs forcing.
   assign target_o    = {raw_tgt[XLEN-1:2], 1'b0, raw_tgt[0]};
   assign misalign_o  = 1'b0;
   assign unused_bits = ^{instr_i[6:0], raw_tgt[1]};
`endif

endmodule

// File: rtl/rv_pc_unit.sv
// rv_pc_unit: byte-addressed program counter at the head of IF.
// Config macro: PC_MISALIGN_CHK_EN (misaligned redirects fault instead of
// being silently aligned).
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   enable            run enable (low requests halt)
//   stall             pipeline busy, PC holds
//   ctl_op, br_taken  next-PC control
//   instr, rs1        immediate source, JALR base
//   trap_valid/vector trap redirect
//   pc, link_addr     current fetch address, pc + 4
//   flush             registered IF/ID flush
//   halt              FSM is HALTED
//   misalign_exc      misaligned-target fault pending, bad_addr holds target
//   redirect_cnt      saturating accepted-redirect count
module rv_pc_unit
   import rv_pc_pkg::*;
#(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int unsigned     CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             stall,
   input  logic [1:0]       ctl_op,
   input  logic             br_taken,
   input  logic [31:0]      instr,
   input  logic [XLEN-1:0]  rs1,
   input  logic             trap_valid,
   input  logic [XLEN-1:0]  trap_vector,
   output logic [XLEN-1:0]  pc,
   output logic [XLEN-1:0]  link_addr,
   output logic             flush,
   output logic             halt,
   output logic             misalign_exc,
   output logic [XLEN-1:0]  bad_addr,
   output logic [CNT_W-1:0] redirect_cnt
);

   pc_state_e       state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            flush_q, flush_d;
   logic            mis_q, mis_d;
   logic [XLEN-1:0] bad_q, bad_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic            cnt_inc;

   logic [XLEN-1:0] target, trap_target;
   logic            redirect, misalign;

   rv_pc_target #(.XLEN(XLEN)) u_target (
      .pc_i          (pc_q),
      .op_i          (ctl_op),
      .br_taken_i    (br_taken),
      .instr_i       (instr),
      .rs1_i         (rs1),
      .trap_vector_i (trap_vector),
      .target_o      (target),
      .trap_target_o (trap_target),
      .redirect_o    (redirect),
      .misalign_o    (misalign)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      flush_d = 1'b0;
      mis_d   = mis_q;
      bad_d   = bad_q;
      cnt_inc = 1'b0;
      if (trap_valid) begin
         pc_d    = trap_target;
         flush_d = 1'b1;
         mis_d   = 1'b0;
         cnt_inc = 1'b1;
         state_d = enable ? RUN : HALTED;
      end else begin
         unique case (state_q)
            BOOT: state_d = enable ? RUN : HALTED;
            RUN: begin
               if (!enable) begin
                  state_d = HALTED;
               end else if (stall) begin
                  state_d = RUN;
               end else if (misalign) begin
                  // misalign is only ever set with the check compiled in.
                  state_d = FAULT;
                  mis_d   = 1'b1;
                  bad_d   = target;
                  flush_d = 1'b1;
               end else begin
                  pc_d    = target;
                  flush_d = redirect;
                  cnt_inc = redirect;
               end
            end
            HALTED: if (enable) state_d = RUN;
            FAULT:  state_d = FAULT;
            default: state_d = BOOT;
         endcase
      end
   end

   assign cnt_d = (cnt_inc && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= BOOT;
         pc_q    <= RESET_VECTOR;
         flush_q <= 1'b1;
         mis_q   <= 1'b0;
         bad_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         flush_q <= flush_d;
         mis_q   <= mis_d;
         bad_q   <= bad_d;
         cnt_q   <= cnt_d;
      end
   end

   assign pc           = pc_q;
   assign link_addr    = pc_q + XLEN'(4);
   assign flush        = flush_q;
   assign halt         = (state_q == HALTED);
   assign misalign_exc = mis_q;
   assign bad_addr     = bad_q;
   assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_rv_pc_unit.sv
module tb_rv_pc_unit;
   import rv_pc_pkg::*;

`ifdef PC_MISALIGN_CHK_EN
   localparam int ADJ = 0;
   localparam bit CHK = 1'b1;
`else
   localparam int ADJ = 1;
   localparam bit CHK = 1'b0;
`endif
   localparam logic [31:0] RV = 32'h100;

   logic        clk = 1'b0;
   logic        rst_n, enable, stall, br_taken, trap_valid;
   logic [1:0]  ctl_op;
   logic [31:0] instr, rs1, trap_vector;
   logic [31:0] pc, link_addr, bad_addr;
   logic        flush, halt, misalign_exc;
   logic [15:0] redirect_cnt;
   logic [31:0] s_pc, s_link, s_bad;
   logic        s_flush, s_halt, s_mis;
   logic [1:0]  s_cnt;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   rv_pc_unit #(.XLEN(32), .RESET_VECTOR(RV), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .stall(stall), .ctl_op(ctl_op),
      .br_taken(br_taken), .instr(instr), .rs1(rs1), .trap_valid(trap_valid),
      .trap_vector(trap_vector), .pc(pc), .link_addr(link_addr), .flush(flush),
      .halt(halt), .misalign_exc(misalign_exc), .bad_addr(bad_addr),
      .redirect_cnt(redirect_cnt));

   rv_pc_unit #(.XLEN(32), .RESET_VECTOR(RV), .CNT_W(2)) dut_s (
      .clk(clk), .rst_n(rst_n), .enable(enable), .stall(stall), .ctl_op(ctl_op),
      .br_taken(br_taken), .instr(instr), .rs1(rs1), .trap_valid(trap_valid),
      .trap_vector(trap_vector), .pc(s_pc), .link_addr(s_link), .flush(s_flush),
      .halt(s_halt), .misalign_exc(s_mis), .bad_addr(s_bad),
      .redirect_cnt(s_cnt));

   typedef struct {
      logic [1:0]  op;
      logic        br;
      int          imm;
      logic [31:0] r1;
      logic        en;
      logic        st;
      logic        trp;
      logic [31:0] tv;
      logic [31:0] e_pc;
      logic        e_flush;
      logic        e_halt;
      logic        e_mis;
      logic [31:0] e_bad;
      int          e_cnt;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic [1:0] op, input logic br, input int imm,
                               input logic [31:0] r1, input logic en, input logic st,
                               input logic trp, input logic [31:0] tv,
                               input logic [31:0] e_pc, input logic e_flush,
                               input logic e_halt, input logic e_mis,
                               input logic [31:0] e_bad, input int e_cnt);
      vec_t v;
      v.op = op; v.br = br; v.imm = imm; v.r1 = r1; v.en = en; v.st = st;
      v.trp = trp; v.tv = tv; v.e_pc = e_pc; v.e_flush = e_flush;
      v.e_halt = e_halt; v.e_mis = e_mis; v.e_bad = e_bad; v.e_cnt = e_cnt;
      return v;
   endfunction

   // Encode an immediate into the matching instruction format; unrelated
   // fields are filled with random bits.
   function automatic logic [31:0] enc(input logic [1:0] op, input int imm);
      logic [31:0] v;
      logic [31:0] r;
      v = imm;
      r = $urandom;
      case (op)
         OP_JAL:    return {v[20], v[10:1], v[11], v[19:12], r[11:0]};
         OP_JALR:   return {v[11:0], r[19:0]};
         OP_BRANCH: return {v[12], v[10:5], r[24:12], v[4:1], v[11], r[6:0]};
         default:   return r;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_all(input logic [31:0] e_pc, input logic e_flush, input logic e_halt,
                            input logic e_mis, input logic [31:0] e_bad, input int e_cnt);
      chk("pc", pc, e_pc);
      chk("link_addr", link_addr, e_pc + 32'd4);
      chk("flush", 32'(flush), 32'(e_flush));
      chk("halt", 32'(halt), 32'(e_halt));
      chk("misalign_exc", 32'(misalign_exc), 32'(e_mis));
      if (!CHK || e_mis) chk("bad_addr", bad_addr, e_bad);
      chk("redirect_cnt", 32'(redirect_cnt), (e_cnt > 65535) ? 32'd65535 : 32'(e_cnt));
      chk("redirect_cnt_sat", 32'(s_cnt), (e_cnt > 3) ? 32'd3 : 32'(e_cnt));
   endtask

   task automatic apply(input logic [1:0] op, input logic br, input int imm,
                        input logic [31:0] r1, input logic en, input logic st,
                        input logic trp, input logic [31:0] tv);
      ctl_op = op; br_taken = br; instr = enc(op, imm); rs1 = r1;
      enable = en; stall = st; trap_valid = trp; trap_vector = tv;
      @(posedge clk);
      #1;
   endtask

   // Reference model state.
   logic [31:0] m_pc, m_bad;
   bit          m_flush, m_mis, m_boot, m_halt, m_fault;
   int          m_cnt;

   task automatic model_reset();
      m_pc = RV; m_flush = 1; m_mis = 0; m_bad = 0;
      m_boot = 1; m_halt = 0; m_fault = 0; m_cnt = 0;
   endtask

   task automatic model_edge(input logic [1:0] op, input logic br, input int imm,
                             input logic [31:0] r1, input logic en, input logic st,
                             input logic trp, input logic [31:0] tv);
      logic [31:0] tgt;
      bit          red;
      if (trp) begin
         m_pc = tv & ~32'd3; m_flush = 1; m_mis = 0; m_cnt++;
         m_halt = !en; m_fault = 0; m_boot = 0;
      end else if (m_boot) begin
         m_boot = 0; m_halt = !en; m_flush = 0;
      end else if (m_fault) begin
         m_flush = 0;
      end else if (m_halt) begin
         m_flush = 0;
         if (en) m_halt = 0;
      end else if (!en) begin
         m_halt = 1; m_flush = 0;
      end else if (st) begin
         m_flush = 0;
      end else begin
         red = 1;
         case (op)
            OP_JAL:    tgt = m_pc + 32'(imm);
            OP_JALR:   tgt = (r1 + 32'(imm)) & ~32'd1;
            OP_BRANCH: begin red = br; tgt = br ? m_pc + 32'(imm) : m_pc + 32'd4; end
            default:   begin red = 0; tgt = m_pc + 32'd4; end
         endcase
         if (red && (tgt % 4 != 0) && CHK) begin
            m_fault = 1; m_mis = 1; m_bad = tgt; m_flush = 1;
         end else begin
            if (red) tgt = tgt & ~32'd2;
            m_pc = tgt; m_flush = red;
            if (red) m_cnt++;
         end
      end
   endtask

   initial begin
      vec_t v;
      rst_n = 0; enable = 1; stall = 0; ctl_op = OP_SEQ; br_taken = 0;
      instr = 0; rs1 = 0; trap_valid = 0; trap_vector = 0;

      // Directed table: op, br, imm, rs1, en, stall, trap, tvec | pc, flush, halt, mis, bad, cnt
      tbl.push_back(mk(OP_SEQ,    0, 0,     0,       1, 0, 0, 0, 32'h100,  0, 0, 0, 0, 0));
      tbl.push_back(mk(OP_SEQ,    0, 0,     0,       1, 0, 0, 0, 32'h104,  0, 0, 0, 0, 0));
      tbl.push_back(mk(OP_SEQ,    0, 0,     0,       1, 0, 0, 0, 32'h108,  0, 0, 0, 0, 0));
      tbl.push_back(mk(OP_JAL,    0, 'hF8,  0,       1, 0, 0, 0, 32'h200,  1, 0, 0, 0, 1));
      tbl.push_back(mk(OP_JAL,    0, 'h20,  0,       1, 0, 0, 0, 32'h220,  1, 0, 0, 0, 2));
      tbl.push_back(mk(OP_SEQ,    0, 0,     0,       1, 0, 0, 0, 32'h224,  0, 0, 0, 0, 2));
      tbl.push_back(mk(OP_JALR,   0, 4,     'h1001,  1, 0, 0, 0, 32'h1004, 1, 0, 0, 0, 3));
      tbl.push_back(mk(OP_BRANCH, 0, 'h40,  0,       1, 0, 0, 0, 32'h1008, 0, 0, 0, 0, 3));
      tbl.push_back(mk(OP_JALR,   0, 0,     'h300,   1, 0, 0, 0, 32'h300,  1, 0, 0, 0, 4));
`ifdef PC_MISALIGN_CHK_EN
      tbl.push_back(mk(OP_BRANCH, 1, 6,     0,       1, 0, 0, 0, 32'h300,  1, 0, 1, 'h306, 4));
      tbl.push_back(mk(OP_SEQ,    0, 0,     0,       1, 0, 0, 0, 32'h300,  0, 0, 1, 'h306, 4));
`else
      tbl.push_back(mk(OP_BRANCH, 1, 6,     0,       1, 0, 0, 0, 32'h304,  1, 0, 0, 0, 5));
      tbl.push_back(mk(OP_SEQ,    0, 0,     0,       1, 0, 0, 0, 32'h308,  0, 0, 0, 0, 5));
`endif
      tbl.push_back(mk(OP_SEQ,    0, 0,     0,       1, 0, 1, 'h83, 32'h80, 1, 0, 0, 0, 5 + ADJ));
      tbl.push_back(mk(OP_BRANCH, 1, 'h10,  0,       0, 0, 0, 0, 32'h80,   0, 1, 0, 0, 5 + ADJ));
      tbl.push_back(mk(OP_SEQ,    0, 0,     0,       0, 0, 0, 0, 32'h80,   0, 1, 0, 0, 5 + ADJ));
      tbl.push_back(mk(OP_SEQ,    0, 0,     0,       1, 0, 0, 0, 32'h80,   0, 0, 0, 0, 5 + ADJ));
      tbl.push_back(mk(OP_SEQ,    0, 0,     0,       1, 0, 0, 0, 32'h84,   0, 0, 0, 0, 5 + ADJ));
      for (int i = 0; i < 3; i++)
         tbl.push_back(mk(OP_JAL, 0, 'h40,  0,       1, 1, 0, 0, 32'h84,   0, 0, 0, 0, 5 + ADJ));
      tbl.push_back(mk(OP_JAL,    0, 'h40,  0,       1, 0, 0, 0, 32'hC4,   1, 0, 0, 0, 6 + ADJ));
      tbl.push_back(mk(OP_SEQ,    0, 0,     0,       1, 0, 1, 'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0, 0, 0, 7 + ADJ));
      tbl.push_back(mk(OP_SEQ,    0, 0,     0,       1, 0, 0, 0, 32'h0,    0, 0, 0, 0, 7 + ADJ));
      tbl.push_back(mk(OP_JAL,    0, -8,    0,       1, 0, 0, 0, 32'hFFFF_FFF8, 1, 0, 0, 0, 8 + ADJ));

      repeat (2) @(posedge clk);
      #1;
      check_all(RV, 1, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1;
      #1;
      check_all(RV, 1, 0, 0, 0, 0);

      foreach (tbl[i]) begin
         v = tbl[i];
         apply(v.op, v.br, v.imm, v.r1, v.en, v.st, v.trp, v.tv);
         check_all(v.e_pc, v.e_flush, v.e_halt, v.e_mis, v.e_bad, v.e_cnt);
      end

      // Asynchronous reset in the middle of a cycle.
      @(posedge clk);
      #3 rst_n = 0;
      #1;
      check_all(RV, 1, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1;
      model_reset();

      // Randomised run against the reference model.
      for (int n = 0; n < 3000; n++) begin
         logic [1:0]  op;
         logic        br, en, st, trp;
         logic [31:0] r1, tv, raw;
         int          imm;
         op  = 2'($urandom_range(0, 3));
         br  = 1'($urandom);
         en  = ($urandom_range(0, 9) != 0);
         st  = ($urandom_range(0, 6) == 0);
         trp = ($urandom_range(0, 19) == 0);
         r1  = $urandom;
         tv  = $urandom;
         raw = $urandom;
         case (op)
            OP_JAL:    imm = int'(raw & 32'h1F_FFFE) - (raw[20] ? 32'h20_0000 : 0);
            OP_JALR:   imm = int'(raw & 32'hFFF) - (raw[11] ? 32'h1000 : 0);
            OP_BRANCH: imm = int'(raw & 32'h1FFE) - (raw[12] ? 32'h2000 : 0);
            default:   imm = 0;
         endcase
         model_edge(op, br, imm, r1, en, st, trp, tv);
         apply(op, br, imm, r1, en, st, trp, tv);
         check_all(m_pc, m_flush, m_halt, m_mis, m_bad, m_cnt);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
